// File: rtl/cordic_kernel_arbiter_if.sv
// Requester-side bus of the CORDIC kernel arbiter: per-requester sample
// handshake plus the shared, non-backpressured response bus.
interface cordic_kernel_arbiter_if #(
  parameter int N_REQ       = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int THETA_WIDTH = 16,
  parameter int ID_WIDTH    = $clog2(N_REQ)
);
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [N_REQ*DATA_WIDTH-1:0] req_data_q;
  logic [N_REQ-1:0]            rsp_valid;
  logic [ID_WIDTH-1:0]         rsp_id;
  logic [DATA_WIDTH-1:0]       rsp_data_i;
  logic [DATA_WIDTH-1:0]       rsp_data_q;
  logic [THETA_WIDTH-1:0]      rsp_theta;

  modport master (
    output req_valid, req_data_i, req_data_q,
    input  req_ready, rsp_valid, rsp_id, rsp_data_i, rsp_data_q, rsp_theta
  );

  modport slave (
    input  req_valid, req_data_i, req_data_q,
    output req_ready, rsp_valid, rsp_id, rsp_data_i, rsp_data_q, rsp_theta
  );
endinterface

// File: rtl/cordic_kernel_arbiter.sv
// Round-robin sharing of one pipelined cordic_kernel between N_REQ requesters;
// a tag pipe matched to the kernel latency routes each result back to its source.
module cordic_kernel_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int THETA_WIDTH    = 16,
  parameter int KERNEL_LATENCY = 16,
  parameter int ID_WIDTH       = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arb_enable,
  cordic_kernel_arbiter_if.slave req_bus,
  output logic [DATA_WIDTH-1:0]  k_data_i,
  output logic [DATA_WIDTH-1:0]  k_data_q,
  output logic                   k_enable,
  input  logic [DATA_WIDTH-1:0]  k_output_data_i,
  input  logic [DATA_WIDTH-1:0]  k_output_data_q,
  input  logic [THETA_WIDTH-1:0] k_output_data_theta,
  input  logic                   k_output_data_valid,
  output logic                   busy,
  input  logic                   err_clear,
  output logic                   err_unexpected,
  output logic                   err_missing
);
  localparam int IFW = $clog2(KERNEL_LATENCY + 2);

  logic [ID_WIDTH-1:0]       rr_ptr;
  logic [ID_WIDTH-1:0]       grant;
  logic [ID_WIDTH-1:0]       cand;
  logic                      found;
  logic                      hs;
  logic [ID_WIDTH-1:0]       issue_id;
  logic [KERNEL_LATENCY-1:0] tag_v;
  logic [ID_WIDTH-1:0]       tag_id [KERNEL_LATENCY];
  logic                      tag_exit;
  logic [ID_WIDTH-1:0]       exit_id;
  logic [N_REQ-1:0]          exit_onehot;
  logic [IFW-1:0]            in_flight;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = ID_WIDTH'((32'(rr_ptr) + i) % N_REQ);
      if (!found && req_bus.req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  assign hs = found & arb_enable;

  always_comb begin
    req_bus.req_ready = '0;
    if (hs) req_bus.req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= ID_WIDTH'(N_REQ - 1);
      k_enable <= 1'b0;
      k_data_i <= '0;
      k_data_q <= '0;
      issue_id <= '0;
    end else begin
      k_enable <= hs;
      if (hs) begin
        rr_ptr   <= grant;
        issue_id <= grant;
        k_data_i <= req_bus.req_data_i[grant*DATA_WIDTH +: DATA_WIDTH];
        k_data_q <= req_bus.req_data_q[grant*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Loaded with the registered enable, so the last stage lines up with the kernel's valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_v <= '0;
      for (int unsigned i = 0; i < KERNEL_LATENCY; i++) tag_id[i] <= '0;
    end else begin
      tag_v     <= {tag_v[KERNEL_LATENCY-2:0], k_enable};
      tag_id[0] <= issue_id;
      for (int unsigned i = 1; i < KERNEL_LATENCY; i++) tag_id[i] <= tag_id[i-1];
    end
  end

  assign tag_exit = tag_v[KERNEL_LATENCY-1];
  assign exit_id  = tag_id[KERNEL_LATENCY-1];

  always_comb begin
    exit_onehot          = '0;
    exit_onehot[exit_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_bus.rsp_valid  <= '0;
      req_bus.rsp_id     <= '0;
      req_bus.rsp_data_i <= '0;
      req_bus.rsp_data_q <= '0;
      req_bus.rsp_theta  <= '0;
    end else if (k_output_data_valid && tag_exit) begin
      req_bus.rsp_valid  <= exit_onehot;
      req_bus.rsp_id     <= exit_id;
      req_bus.rsp_data_i <= k_output_data_i;
      req_bus.rsp_data_q <= k_output_data_q;
      req_bus.rsp_theta  <= k_output_data_theta;
    end else begin
      req_bus.rsp_valid <= '0;
    end
  end

  // A new error in the same cycle as err_clear keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_unexpected <= 1'b0;
      err_missing    <= 1'b0;
    end else begin
      if (k_output_data_valid && !tag_exit) err_unexpected <= 1'b1;
      else if (err_clear)                   err_unexpected <= 1'b0;
      if (tag_exit && !k_output_data_valid) err_missing <= 1'b1;
      else if (err_clear)                   err_missing <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_flight <= '0;
    end else begin
      case ({hs, tag_exit})
        2'b10:   in_flight <= in_flight + IFW'(1);
        2'b01:   in_flight <= in_flight - IFW'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  assign busy = (in_flight != '0);
endmodule

// File: tb/tb_cordic_kernel_arbiter.sv
// Directed bench for cordic_kernel_arbiter with a latency-matched kernel model
// (out_i = i+1, out_q = q+2, theta = i^q) and an optional one-cycle extra delay.
module tb_cordic_kernel_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int TW = 16;
  localparam int KL = 16;

  logic clk = 1'b0;
  logic reset;
  logic arb_enable;
  logic err_clear;
  logic [DW-1:0] k_data_i, k_data_q;
  logic k_enable;
  logic [DW-1:0] k_output_data_i, k_output_data_q;
  logic [TW-1:0] k_output_data_theta;
  logic k_output_data_valid;
  logic busy, err_unexpected, err_missing;
  logic extra;

  int checks = 0;
  int errors = 0;

  cordic_kernel_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW), .THETA_WIDTH(TW)) bus ();

  cordic_kernel_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .THETA_WIDTH(TW), .KERNEL_LATENCY(KL)
  ) dut (
    .clk(clk), .reset(reset), .arb_enable(arb_enable), .req_bus(bus),
    .k_data_i(k_data_i), .k_data_q(k_data_q), .k_enable(k_enable),
    .k_output_data_i(k_output_data_i), .k_output_data_q(k_output_data_q),
    .k_output_data_theta(k_output_data_theta), .k_output_data_valid(k_output_data_valid),
    .busy(busy), .err_clear(err_clear),
    .err_unexpected(err_unexpected), .err_missing(err_missing)
  );

  always #5 clk = ~clk;

  // Kernel model: KL-stage pipe (KL+1 stages when extra is set); resets with the arbiter.
  logic          kv [0:KL];
  logic [DW-1:0] ki [0:KL];
  logic [DW-1:0] kq [0:KL];
  logic [TW-1:0] kt [0:KL];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= KL; i++) kv[i] <= 1'b0;
    end else begin
      kv[0] <= k_enable;
      ki[0] <= k_data_i + 16'd1;
      kq[0] <= k_data_q + 16'd2;
      kt[0] <= k_data_i ^ k_data_q;
      for (int i = 1; i <= KL; i++) begin
        kv[i] <= kv[i-1];
        ki[i] <= ki[i-1];
        kq[i] <= kq[i-1];
        kt[i] <= kt[i-1];
      end
    end
  end

  assign k_output_data_valid = extra ? kv[KL] : kv[KL-1];
  assign k_output_data_i     = extra ? ki[KL] : ki[KL-1];
  assign k_output_data_q     = extra ? kq[KL] : kq[KL-1];
  assign k_output_data_theta = extra ? kt[KL] : kt[KL-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [DW-1:0] di, input logic [DW-1:0] dq);
    bus.req_data_i[k*DW +: DW] = di;
    bus.req_data_q[k*DW +: DW] = dq;
  endtask

  int n;
  int spurious;
  logic [1:0] exp_ids [5];

  initial begin
    reset         = 1'b0;
    arb_enable    = 1'b1;
    err_clear     = 1'b0;
    extra         = 1'b0;
    bus.req_valid  = '0;
    bus.req_data_i = '0;
    bus.req_data_q = '0;
    #1;
    chk("rst_k_enable", 32'(k_enable), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_errs", 32'({err_unexpected, err_missing}), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    next();

    // All four requesters for eight cycles: grants 0,1,2,3,0,1,2,3
    for (int j = 0; j < 8; j++) begin
      bus.req_valid = 4'b1111;
      for (int k = 0; k < N; k++) set_data(k, 16'(j*16 + k), 16'(j*16 + k + 8));
      #1;
      chk("rr_ready", 32'(bus.req_ready), 32'd1 << (j % 4));
      if (j > 0) begin
        chk("rr_k_enable", 32'(k_enable), 32'd1);
        chk("rr_k_data_i", 32'(k_data_i), 32'((j-1)*16 + (j-1) % 4));
      end
      next();
    end
    bus.req_valid = '0;
    chk("rr_k_data_last", 32'(k_data_i), 32'(7*16 + 3));
    repeat (10) next();
    for (int j = 0; j < 8; j++) begin
      chk("rr_rsp_valid", 32'(bus.rsp_valid), 32'd1 << (j % 4));
      chk("rr_rsp_id", 32'(bus.rsp_id), 32'(j % 4));
      chk("rr_rsp_i", 32'(bus.rsp_data_i), 32'(j*16 + j % 4 + 1));
      chk("rr_rsp_q", 32'(bus.rsp_data_q), 32'(j*16 + j % 4 + 10));
      chk("rr_rsp_theta", 32'(bus.rsp_theta), 32'd8);
      chk("rr_busy", 32'(busy), (j < 7) ? 32'd1 : 32'd0);
      next();
    end
    chk("rr_rsp_done", 32'(bus.rsp_valid), 32'd0);

    // Single request latency
    bus.req_valid = 4'b0001;
    set_data(0, 16'd1000, 16'd0);
    #1;
    chk("one_ready", 32'(bus.req_ready), 32'd1);
    next();
    bus.req_valid = '0;
    chk("one_k_enable", 32'(k_enable), 32'd1);
    chk("one_k_data_i", 32'(k_data_i), 32'd1000);
    chk("one_k_data_q", 32'(k_data_q), 32'd0);
    chk("one_busy", 32'(busy), 32'd1);
    repeat (16) next();
    chk("one_early", 32'(bus.rsp_valid), 32'd0);
    next();
    chk("one_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("one_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("one_rsp_i", 32'(bus.rsp_data_i), 32'd1001);
    chk("one_rsp_q", 32'(bus.rsp_data_q), 32'd2);
    chk("one_rsp_theta", 32'(bus.rsp_theta), 32'd1000);
    chk("one_busy_end", 32'(busy), 32'd0);
    next();
    chk("one_rsp_pulse", 32'(bus.rsp_valid), 32'd0);

    // rr_ptr=2, requesters 1 and 3 pending: 3 then 1
    bus.req_valid = 4'b0100;
    #1;
    chk("ptr_set_ready", 32'(bus.req_ready), 32'b0100);
    next();
    bus.req_valid = 4'b1010;
    #1;
    chk("ptr_grant3", 32'(bus.req_ready), 32'b1000);
    next();
    chk("ptr_grant1", 32'(bus.req_ready), 32'b0010);
    next();
    bus.req_valid = '0;
    repeat (20) next();
    chk("ptr_drain_busy", 32'(busy), 32'd0);
    chk("ptr_drain_errs", 32'({err_unexpected, err_missing}), 32'd0);

    // Five issues, then arb_enable low with three pending; rr_ptr=1 -> 2,0,1,2,0
    exp_ids = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    bus.req_valid = 4'b0111;
    repeat (5) next();
    arb_enable = 1'b0;
    #1;
    chk("hold_ready", 32'(bus.req_ready), 32'd0);
    chk("hold_busy", 32'(busy), 32'd1);
    n = 0;
    for (int c = 0; c < 30; c++) begin
      next();
      if (bus.rsp_valid != '0) begin
        if (n < 5) chk("hold_rsp_id", 32'(bus.rsp_id), 32'(exp_ids[n]));
        n++;
      end
    end
    chk("hold_rsp_count", 32'(n), 32'd5);
    chk("hold_busy_end", 32'(busy), 32'd0);
    chk("hold_ready_end", 32'(bus.req_ready), 32'd0);
    bus.req_valid = '0;
    arb_enable = 1'b1;
    next();

    // Kernel one cycle late: missing, then unexpected; clear with a new error wins
    extra = 1'b1;
    bus.req_valid = 4'b0001;
    next();
    bus.req_valid = '0;
    repeat (16) next();
    chk("late_missing_pre", 32'(err_missing), 32'd0);
    next();
    chk("late_missing", 32'(err_missing), 32'd1);
    chk("late_unexp_pre", 32'(err_unexpected), 32'd0);
    chk("late_no_rsp0", 32'(bus.rsp_valid), 32'd0);
    err_clear = 1'b1;
    next();
    chk("late_clr_missing", 32'(err_missing), 32'd0);
    chk("late_unexp_wins", 32'(err_unexpected), 32'd1);
    chk("late_no_rsp1", 32'(bus.rsp_valid), 32'd0);
    next();
    err_clear = 1'b0;
    chk("late_cleared", 32'({err_unexpected, err_missing}), 32'd0);
    chk("late_busy", 32'(busy), 32'd0);
    extra = 1'b0;
    next();

    // Reset with five in flight
    bus.req_valid = 4'b0001;
    set_data(0, 16'h1234, 16'h0042);
    repeat (5) next();
    bus.req_valid = '0;
    chk("prerst_k_enable", 32'(k_enable), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("arst_k_enable", 32'(k_enable), 32'd0);
    chk("arst_k_data_i", 32'(k_data_i), 32'd0);
    chk("arst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("arst_rsp_i", 32'(bus.rsp_data_i), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_errs", 32'({err_unexpected, err_missing}), 32'd0);
    chk("arst_ready", 32'(bus.req_ready), 32'd0);
    repeat (2) next();
    reset = 1'b1;
    spurious = 0;
    for (int c = 0; c < 25; c++) begin
      next();
      if (bus.rsp_valid != '0 || err_unexpected || err_missing) spurious++;
    end
    chk("post_rst_quiet", 32'(spurious), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
